opl_stats_counters: RTL and testbench
=====================================

# opl_stats_counters

Statistics stage for the output port lookup: monitors the lookup's input and output AXI-Stream handshakes plus per-packet metadata and maintains the packet, ICMP and target-IP counters read by the CPU register block. It sits directly beside the register block: it produces `pktin_reg`, `pktout_reg`, `icmpout_reg`, `tgtipout_reg` and `tgtipoutlst_reg`, and consumes the register block's `*_reg_clear` pulses and `cpu2ip_tgtipaddr_reg`.

## Interface
- `C_CNT_WIDTH`, 32: width of every counter and timestamp output.
- `C_META_DEPTH`, 4: metadata FIFO depth; power of two, at least 2.
- `clk`  in  1  single clock for all logic.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_tvalid`, `in_tready`, `in_tlast`  in  1 each  monitored lookup input stream.
- `out_tvalid`, `out_tready`, `out_tlast`  in  1 each  monitored lookup output stream.
- `meta_valid`  in  1  per-packet metadata strobe from the lookup decode.
- `meta_ready`  out  1  FIFO not full.
- `meta_is_icmp`  in  1  packet is a generated ICMP reply.
- `meta_dst_ip`  in  32  packet destination IPv4 address.
- `cpu2ip_tgtipaddr_reg`  in  32  target IP; 0 disables matching.
- `pktin_reg_clear`, `pktout_reg_clear`, `icmpout_reg_clear`, `tgtipout_reg_clear`  in  1 each  clear pulses.
- `pktin_reg`, `pktout_reg`, `icmpout_reg`, `tgtipout_reg`  out  C_CNT_WIDTH  counters.
- `tgtipoutlst_reg`  out  C_CNT_WIDTH  timestamp of the last matching output packet.
- `meta_underflow`  out  1  sticky error flag.

## Operation
- Input end-of-packet (`in_eop`) = `in_tvalid & in_tready & in_tlast`. Output end-of-packet (`out_eop`) is defined the same way on the `out_*` signals.
- `pktin_reg` increments on `in_eop`. `pktout_reg` increments on `out_eop`.
- Metadata FIFO:
  - Push on `meta_valid & meta_ready`.
  - Pop on `out_eop` when the FIFO is not empty.
  - There is no bypass: an entry pushed in the same cycle as a pop is not visible to that pop.
  - Upstream must deliver metadata before the packet's output `tlast`.
- `out_eop` with the FIFO empty:
  - Set `meta_underflow`. It clears only on reset.
  - Increment no ICMP or target counter; `pktout_reg` still increments.
- On a pop:
  - If `is_icmp`, `icmpout_reg` increments.
  - If `dst_ip == cpu2ip_tgtipaddr_reg` and `cpu2ip_tgtipaddr_reg != 0`, `tgtipout_reg` increments and `tgtipoutlst_reg` is loaded with the timestamp.
  - The comparison uses `cpu2ip_tgtipaddr_reg` as sampled in the pop cycle.
- Timestamp: free-running C_CNT_WIDTH counter that increments every cycle and wraps to 0.
- Counter rules, applied to each counter:
  - Next value is, in priority order: clear & event gives 1; clear gives 0; event gives saturating +1; otherwise hold.
  - Counters saturate at all-ones and never wrap.
  - A clear held for N cycles keeps the counter at 0 or 1 on each of those cycles; no event is lost.
- `tgtipoutlst_reg` is unaffected by every clear.

## Timing
- Reset: all counters, `tgtipoutlst_reg`, the timestamp, FIFO pointers and `meta_underflow` are 0; `meta_ready` is 1.
- Counter outputs update on the clock edge after the qualifying handshake (1-cycle latency). Clears take effect with the same 1-cycle latency.
- `meta_ready` is registered and equals !full.
  - A push into the last free slot drops `meta_ready` the next cycle.
  - A push and pop in the same cycle leave the occupancy unchanged.
- `tgtipoutlst_reg` holds the timestamp value of the pop cycle.
- Reset asserted mid-packet discards all state. After release, counting restarts with the next `tlast` handshake and no partial-packet recovery is attempted.

## Structure
- Package `opl_stats_pkg`:
  - `opl_meta_t` struct (`is_icmp`, `dst_ip[31:0]`).
  - Counter update function (clear/event/saturate).
- Sub-module `opl_meta_fifo`:
  - Synchronous FIFO of `opl_meta_t`, parameterised by depth.
  - Async active-low reset.
  - Registered full/empty flags, extra-bit pointers.
- Top level holds the counters, the timestamp and the matching logic.

## Test plan
- Reset and idle: after reset release, all outputs are 0, `meta_ready`=1, and after 10 cycles the counters are still 0.
- 3 input and 3 output packets, each with non-matching, non-ICMP metadata: `pktin_reg`=3 and `pktout_reg`=3 on the cycle after the last `tlast`; ICMP and target counters are 0.
- Target match: `cpu2ip_tgtipaddr_reg`=0x0A000001; 2 packets with that `dst_ip` and 1 with ICMP set: `tgtipout_reg`=2, `icmpout_reg`=1, and `tgtipoutlst_reg` equals the timestamp of the second pop. Repeating with the target at 0 leaves `tgtipout_reg` unchanged.
- Simultaneous clear and event: `pktout_reg`=5, then `pktout_reg_clear` is asserted in the same cycle as an `out_eop`: next value is 1. A clear alone gives 0.
- FIFO full and underflow:
  - 4 pushes with no pops drop `meta_ready` to 0 on the next cycle; one pop raises it again.
  - `out_eop` with the FIFO empty sets `meta_underflow`=1, increments `pktout_reg` only, and the flag stays set.
- Saturation: force `pktin_reg` to 0xFFFFFFFE via 0xFFFFFFFE events (or a backdoor), then apply 2 more events: `pktin_reg` holds 0xFFFFFFFF.

Source files
------------

// File: rtl/opl_stats_pkg.sv
// Shared types and helpers for the output port lookup statistics stage.
// Holds the per-packet metadata record and the counter update rule.
package opl_stats_pkg;

    typedef struct packed {
        logic        is_icmp;
        logic [31:0] dst_ip;
    } opl_meta_t;

    // Widest counter the update helper handles.
    localparam int CNT_MAX_W = 64;

    // Counter update: clear plus event gives 1, clear alone gives 0,
    // event alone gives a +1 that saturates at max_v.
    function automatic logic [CNT_MAX_W-1:0] cnt_next(
        input logic [CNT_MAX_W-1:0] cur,
        input logic [CNT_MAX_W-1:0] max_v,
        input logic                 clr,
        input logic                 ev
    );
        logic [CNT_MAX_W-1:0] nxt;
        nxt = cur;
        if (clr && ev) begin
            nxt = CNT_MAX_W'(1);
        end else if (clr) begin
            nxt = '0;
        end else if (ev && (cur != max_v)) begin
            nxt = cur + CNT_MAX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/opl_stats_counters_if.sv
// Monitored lookup input/output streams plus the metadata strobe.
// The stats block only observes the streams; it drives meta_ready.
interface opl_stats_counters_if;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        meta_valid;
    logic        meta_ready;
    logic        meta_is_icmp;
    logic [31:0] meta_dst_ip;

    modport master (
        output in_tvalid, in_tready, in_tlast,
        output out_tvalid, out_tready, out_tlast,
        output meta_valid, meta_is_icmp, meta_dst_ip,
        input  meta_ready
    );

    modport slave (
        input  in_tvalid, in_tready, in_tlast,
        input  out_tvalid, out_tready, out_tlast,
        input  meta_valid, meta_is_icmp, meta_dst_ip,
        output meta_ready
    );
endinterface

// File: rtl/opl_meta_fifo.sv
// Synchronous metadata FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit; reads never bypass a same-cycle write.
module opl_meta_fifo
    import opl_stats_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push_i,
    input  opl_meta_t din_i,
    input  logic      pop_i,
    output opl_meta_t dout_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        push, pop;
    opl_meta_t   mem_q [DEPTH];

    assign push = push_i & ~full_q;
    assign pop  = pop_i & ~empty_q;

    // Next pointers and the flags they imply after this cycle.
    always_comb begin
        wr_d    = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = pop  ? rd_q + (AW+1)'(1) : rd_q;
        full_d  = (wr_d[AW] != rd_d[AW])
                && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        empty_d = (wr_d == rd_d);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/opl_stats_counters.sv
// Output port lookup statistics: packet, ICMP and target-IP counters.
// Metadata is queued per packet and consumed on each output tlast.
module opl_stats_counters
    import opl_stats_pkg::*;
#(
    parameter int C_CNT_WIDTH  = 32,
    parameter int C_META_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    opl_stats_counters_if.slave    s,
    input  logic [31:0]            cpu2ip_tgtipaddr_reg,
    input  logic                   pktin_reg_clear,
    input  logic                   pktout_reg_clear,
    input  logic                   icmpout_reg_clear,
    input  logic                   tgtipout_reg_clear,
    output logic [C_CNT_WIDTH-1:0] pktin_reg,
    output logic [C_CNT_WIDTH-1:0] pktout_reg,
    output logic [C_CNT_WIDTH-1:0] icmpout_reg,
    output logic [C_CNT_WIDTH-1:0] tgtipout_reg,
    output logic [C_CNT_WIDTH-1:0] tgtipoutlst_reg,
    output logic                   meta_underflow
);

    localparam logic [C_CNT_WIDTH-1:0] CMAX = '1;

    logic      in_eop, out_eop;
    logic      push, pop, fifo_full, fifo_empty;
    logic      icmp_ev, tgt_ev;
    opl_meta_t fifo_dout, fifo_din;

    logic [C_CNT_WIDTH-1:0] pktin_q, pktin_d;
    logic [C_CNT_WIDTH-1:0] pktout_q, pktout_d;
    logic [C_CNT_WIDTH-1:0] icmp_q, icmp_d;
    logic [C_CNT_WIDTH-1:0] tgt_q, tgt_d;
    logic [C_CNT_WIDTH-1:0] lst_q, lst_d;
    logic [C_CNT_WIDTH-1:0] ts_q, ts_d;
    logic                   unf_q, unf_d;

    assign in_eop  = s.in_tvalid & s.in_tready & s.in_tlast;
    assign out_eop = s.out_tvalid & s.out_tready & s.out_tlast;
    assign push    = s.meta_valid & s.meta_ready;
    assign pop     = out_eop & ~fifo_empty;

    assign fifo_din.is_icmp = s.meta_is_icmp;
    assign fifo_din.dst_ip  = s.meta_dst_ip;

    opl_meta_fifo #(
        .DEPTH (C_META_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s.meta_ready = ~fifo_full;

    assign icmp_ev = pop & fifo_dout.is_icmp;
    assign tgt_ev  = pop
                   & (fifo_dout.dst_ip == cpu2ip_tgtipaddr_reg)
                   & (cpu2ip_tgtipaddr_reg != 32'd0);

    // Next-state for every counter, the timestamp and the error flag.
    always_comb begin
        pktin_d  = C_CNT_WIDTH'(cnt_next(CNT_MAX_W'(pktin_q),
                   CNT_MAX_W'(CMAX), pktin_reg_clear, in_eop));
        pktout_d = C_CNT_WIDTH'(cnt_next(CNT_MAX_W'(pktout_q),
                   CNT_MAX_W'(CMAX), pktout_reg_clear, out_eop));
        icmp_d   = C_CNT_WIDTH'(cnt_next(CNT_MAX_W'(icmp_q),
                   CNT_MAX_W'(CMAX), icmpout_reg_clear, icmp_ev));
        tgt_d    = C_CNT_WIDTH'(cnt_next(CNT_MAX_W'(tgt_q),
                   CNT_MAX_W'(CMAX), tgtipout_reg_clear, tgt_ev));
        lst_d    = tgt_ev ? ts_q : lst_q;
        ts_d     = ts_q + C_CNT_WIDTH'(1);
        unf_d    = unf_q | (out_eop & fifo_empty);
    end

    // Statistics registers; the last-match timestamp ignores clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pktin_q  <= '0;
            pktout_q <= '0;
            icmp_q   <= '0;
            tgt_q    <= '0;
            lst_q    <= '0;
            ts_q     <= '0;
            unf_q    <= 1'b0;
        end else begin
            pktin_q  <= pktin_d;
            pktout_q <= pktout_d;
            icmp_q   <= icmp_d;
            tgt_q    <= tgt_d;
            lst_q    <= lst_d;
            ts_q     <= ts_d;
            unf_q    <= unf_d;
        end
    end

    assign pktin_reg       = pktin_q;
    assign pktout_reg      = pktout_q;
    assign icmpout_reg     = icmp_q;
    assign tgtipout_reg    = tgt_q;
    assign tgtipoutlst_reg = lst_q;
    assign meta_underflow  = unf_q;

endmodule

// File: tb/tb_opl_stats_counters.sv
// Directed bench for opl_stats_counters.
// A second, 4-bit-wide instance exercises counter saturation.
module tb_opl_stats_counters;

    logic        clk;
    logic        resetn;
    logic [31:0] tgt;
    logic        c_in, c_out, c_icmp, c_tgt;
    logic [31:0] pktin, pktout, icmp, tgtcnt, lst;
    logic        unf;
    logic [3:0]  n_pktin, n_pktout, n_icmp, n_tgt, n_lst;
    logic        n_unf;

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [31:0] cyc;
    logic [31:0] exp_lst;
    logic [31:0] e_out;
    logic [31:0] e_icmp;

    opl_stats_counters_if bus ();
    opl_stats_counters_if nb ();

    opl_stats_counters #(
        .C_CNT_WIDTH  (32),
        .C_META_DEPTH (4)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .s                    (bus),
        .cpu2ip_tgtipaddr_reg (tgt),
        .pktin_reg_clear      (c_in),
        .pktout_reg_clear     (c_out),
        .icmpout_reg_clear    (c_icmp),
        .tgtipout_reg_clear   (c_tgt),
        .pktin_reg            (pktin),
        .pktout_reg           (pktout),
        .icmpout_reg          (icmp),
        .tgtipout_reg         (tgtcnt),
        .tgtipoutlst_reg      (lst),
        .meta_underflow       (unf)
    );

    opl_stats_counters #(
        .C_CNT_WIDTH  (4),
        .C_META_DEPTH (2)
    ) dut_n (
        .clk                  (clk),
        .resetn               (resetn),
        .s                    (nb),
        .cpu2ip_tgtipaddr_reg (32'd0),
        .pktin_reg_clear      (1'b0),
        .pktout_reg_clear     (1'b0),
        .icmpout_reg_clear    (1'b0),
        .tgtipout_reg_clear   (1'b0),
        .pktin_reg            (n_pktin),
        .pktout_reg           (n_pktout),
        .icmpout_reg          (n_icmp),
        .tgtipout_reg         (n_tgt),
        .tgtipoutlst_reg      (n_lst),
        .meta_underflow       (n_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: equals the timestamp of the current cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= '0;
        else         cyc <= cyc + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_tvalid    = 1'b0;
        bus.in_tready    = 1'b0;
        bus.in_tlast     = 1'b0;
        bus.out_tvalid   = 1'b0;
        bus.out_tready   = 1'b0;
        bus.out_tlast    = 1'b0;
        bus.meta_valid   = 1'b0;
        bus.meta_is_icmp = 1'b0;
        bus.meta_dst_ip  = '0;
        c_in   = 1'b0;
        c_out  = 1'b0;
        c_icmp = 1'b0;
        c_tgt  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic ic, input logic [31:0] ip);
        bus.meta_valid   = 1'b1;
        bus.meta_is_icmp = ic;
        bus.meta_dst_ip  = ip;
        tick();
        bus.meta_valid   = 1'b0;
    endtask

    task automatic set_out();
        bus.out_tvalid = 1'b1;
        bus.out_tready = 1'b1;
        bus.out_tlast  = 1'b1;
    endtask

    task automatic outeop();
        set_out();
        tick();
        idle();
    endtask

    initial begin
        idle();
        nb.in_tvalid = 1'b0; nb.in_tready = 1'b0; nb.in_tlast = 1'b0;
        nb.out_tvalid = 1'b0; nb.out_tready = 1'b0; nb.out_tlast = 1'b0;
        nb.meta_valid = 1'b0; nb.meta_is_icmp = 1'b0;
        nb.meta_dst_ip = '0;
        tgt = '0;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;

        // Reset and idle
        chk("rst_pktin", pktin, 0);
        chk("rst_pktout", pktout, 0);
        chk("rst_icmp", icmp, 0);
        chk("rst_tgt", tgtcnt, 0);
        chk("rst_lst", lst, 0);
        chk("rst_unf", unf, 0);
        chk("rst_ready", bus.meta_ready, 1);
        repeat (10) tick();
        chk("idle_pktin", pktin, 0);
        chk("idle_pktout", pktout, 0);

        // Three two-beat packets in, three out
        for (int p = 0; p < 3; p++) begin
            bus.meta_valid   = 1'b1;
            bus.meta_dst_ip  = 32'h0102_0304;
            bus.in_tvalid    = 1'b1;
            bus.in_tready    = 1'b1;
            tick();
            bus.meta_valid   = 1'b0;
            bus.in_tlast     = 1'b1;
            set_out();
            tick();
            idle();
        end
        chk("pk_pktin", pktin, 3);
        chk("pk_pktout", pktout, 3);
        chk("pk_icmp", icmp, 0);
        chk("pk_tgt", tgtcnt, 0);
        bus.in_tvalid  = 1'b1;
        bus.in_tlast   = 1'b1;
        bus.out_tready = 1'b1;
        bus.out_tlast  = 1'b1;
        tick();
        idle();
        chk("stall_pktin", pktin, 3);
        chk("stall_pktout", pktout, 3);

        // Target match and ICMP
        tgt = 32'h0A00_0001;
        push(1'b0, 32'h0A00_0001);
        push(1'b1, 32'h0A00_0002);
        push(1'b0, 32'h0A00_0001);
        outeop();
        outeop();
        exp_lst = cyc;
        outeop();
        chk("tg_cnt", tgtcnt, 2);
        chk("tg_icmp", icmp, 1);
        chk("tg_lst", lst, exp_lst);
        chk("tg_pktout", pktout, 6);
        tgt = '0;
        push(1'b0, 32'h0);
        outeop();
        chk("tg0_cnt", tgtcnt, 2);
        chk("tg0_lst", lst, exp_lst);

        // FIFO full, simultaneous push/pop, drain, underflow
        e_out  = 32'd7;
        e_icmp = 32'd1;
        push(1'b1, 32'h1);
        push(1'b0, 32'h2);
        push(1'b0, 32'h3);
        chk("ff_ready3", bus.meta_ready, 1);
        push(1'b1, 32'h4);
        chk("ff_full", bus.meta_ready, 0);
        push(1'b1, 32'h5);
        chk("ff_stay", bus.meta_ready, 0);
        outeop();
        e_out++; e_icmp++;
        chk("ff_pop1", bus.meta_ready, 1);
        chk("ff_icmp1", icmp, e_icmp);
        bus.meta_valid  = 1'b1;
        bus.meta_dst_ip = 32'h6;
        set_out();
        tick();
        idle();
        e_out++;
        chk("ff_pp_ready", bus.meta_ready, 1);
        chk("ff_pp_icmp", icmp, e_icmp);
        push(1'b0, 32'h7);
        chk("ff_refull", bus.meta_ready, 0);
        for (int k = 0; k < 4; k++) outeop();
        e_out += 4; e_icmp++;
        chk("ff_drain_icmp", icmp, e_icmp);
        chk("ff_drain_unf", unf, 0);
        chk("ff_drain_out", pktout, e_out);
        outeop();
        e_out++;
        chk("uf_flag", unf, 1);
        chk("uf_pktout", pktout, e_out);
        chk("uf_icmp", icmp, e_icmp);
        repeat (3) tick();
        chk("uf_sticky", unf, 1);

        // Clear behaviour
        c_out = 1'b1;
        tick();
        idle();
        chk("clr_zero", pktout, 0);
        for (int k = 0; k < 5; k++) outeop();
        chk("clr_five", pktout, 5);
        c_out = 1'b1;
        set_out();
        tick();
        idle();
        chk("clr_ev", pktout, 1);
        c_out = 1'b1;
        tick();
        chk("clr_hold0", pktout, 0);
        set_out();
        tick();
        idle();
        chk("clr_hold1", pktout, 1);
        c_tgt = 1'b1;
        c_icmp = 1'b1;
        tick();
        idle();
        chk("clr_tgt", tgtcnt, 0);
        chk("clr_icmp", icmp, 0);
        chk("clr_lst", lst, exp_lst);
        c_in = 1'b1;
        bus.in_tvalid = 1'b1;
        bus.in_tready = 1'b1;
        bus.in_tlast  = 1'b1;
        tick();
        idle();
        chk("clr_pktin_ev", pktin, 1);

        // Saturation on the 4-bit instance
        nb.in_tvalid = 1'b1;
        nb.in_tready = 1'b1;
        nb.in_tlast  = 1'b1;
        repeat (14) tick();
        chk("sat_14", n_pktin, 4'hE);
        repeat (2) tick();
        chk("sat_max", n_pktin, 4'hF);
        tick();
        chk("sat_hold", n_pktin, 4'hF);
        nb.in_tvalid = 1'b0;

        // Reset mid-packet, then count from the next tlast
        bus.in_tvalid = 1'b1;
        bus.in_tready = 1'b1;
        tick();
        resetn = 1'b0;
        #1;
        chk("mrst_pktin", pktin, 0);
        chk("mrst_unf", unf, 0);
        chk("mrst_lst", lst, 0);
        chk("mrst_ready", bus.meta_ready, 1);
        tick();
        resetn = 1'b1;
        bus.in_tlast = 1'b1;
        tick();
        idle();
        chk("mrst_after", pktin, 1);
        chk("mrst_pktout", pktout, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
